sensor_conditioner: RTL and testbench
=====================================

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth per sensor input (legal values 2..3).
REQ-002 Parameter DEBOUNCE_CYC, default 50000, is the number of clk cycles a new input level must hold before it is accepted (1 ms at 50 MHz).
REQ-003 Parameter SEQ_TIMEOUT, default 50000000, is the maximum number of clk cycles allowed between consecutive sensor rises of one vehicle.
REQ-004 Parameter STUCK_CYC, default 100000000, is the number of cycles a clean level may stay high before it is flagged stuck.
REQ-005 Port list:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- sensor_raw  in  3  raw sensor inputs, bit0 = sensor1, bit2 = sensor3; asynchronous to clk.
- sensor_clean  out  3  debounced sensor levels that drive the non_stop_ETC sensor1..3 inputs.
- sensor_rise  out  3  one-cycle pulse on each 0->1 transition of sensor_clean.
- seq_done  out  1  one-cycle pulse when a valid 1->2->3 order completes.
- seq_error  out  1  one-cycle pulse on an order violation or timeout.
- stuck  out  3  level flag per channel; sensor_clean[i] has been high for at least STUCK_CYC cycles.

Function
REQ-006 Each sensor_raw bit SHALL pass through a SYNC_STAGES-deep flip-flop synchronizer before any other use.
REQ-007 Each channel SHALL have a debounce counter, width clog2(DEBOUNCE_CYC).
- The counter SHALL clear whenever the synchronized bit equals sensor_clean[i].
- The counter SHALL increment while the two differ.
REQ-008 When the counter equals DEBOUNCE_CYC-1 and the mismatch persists, sensor_clean[i] SHALL toggle on the next edge and the counter SHALL clear.
REQ-009 A raw change held stable SHALL appear on sensor_clean exactly SYNC_STAGES+DEBOUNCE_CYC cycles later.
- A glitch shorter than DEBOUNCE_CYC synchronized cycles SHALL produce no output change.
REQ-010 sensor_rise[i] SHALL be high for exactly the first cycle in which sensor_clean[i] is 1 after being 0; there is no falling-edge pulse.
REQ-011 The sequence FSM SHALL have three states: IDLE, GOT1 and GOT2.
REQ-012 The following applies in IDLE:
- rise1 alone -> GOT1.
- rise2 or rise3 -> seq_error and remain in IDLE.
REQ-013 The following applies in GOT1:
- rise2 alone -> GOT2.
- rise1 alone -> remain in GOT1, restart the timer, no error.
- rise3 -> seq_error, go to IDLE.
REQ-014 The following applies in GOT2:
- rise3 alone -> seq_done, go to IDLE.
- rise1 alone -> seq_error, go to GOT1.
- rise2 -> seq_error, go to IDLE.
REQ-015 If two or more sensor_rise bits are high in the same cycle, in any state, the FSM SHALL pulse seq_error and go to IDLE; this rule has priority over REQ-012 to REQ-014.
REQ-016 The sequence timer SHALL have width clog2(SEQ_TIMEOUT+1).
- It SHALL clear on every state entry.
- It SHALL count in GOT1 and GOT2.
- On reaching SEQ_TIMEOUT, the FSM SHALL pulse seq_error and go to IDLE.
- A rise that arrives in the timeout cycle SHALL be ignored.
REQ-017 seq_done and seq_error SHALL be registered, SHALL be mutually exclusive, and SHALL each be high for one cycle, one cycle after the causing sensor_rise or timeout.
REQ-018 Each channel SHALL have a stuck counter that saturates at STUCK_CYC while sensor_clean[i] = 1 and clears when it is 0.
- stuck[i] SHALL be 1 while the counter equals STUCK_CYC.
- stuck[i] SHALL fall in the same cycle that sensor_clean[i] falls.
REQ-019 All counters SHALL saturate or clear and SHALL never wrap.

Reset
REQ-020 Asserting reset SHALL immediately clear the following:
- synchronizers;
- all counters;
- sensor_clean = 3'b000, sensor_rise = 3'b000, stuck = 3'b000;
- seq_done = 0, seq_error = 0;
- FSM = IDLE.
REQ-021 On reset release with sensor_raw already high, that channel SHALL debounce from 0 and produce one sensor_rise after SYNC_STAGES+DEBOUNCE_CYC cycles.
REQ-022 Reset asserted mid-sequence SHALL abandon the sequence without pulsing seq_error.

Structure
REQ-023 The FSM state encoding and the channel count (3) SHALL live in the shared package etc_pkg.
REQ-024 The synchronizer, the debounce counter and the rise detector SHALL form one sub-module, sensor_debounce, instantiated three times.
- The sequence FSM, the timer and the stuck counters SHALL stay in sensor_conditioner.

Verification
REQ-025 Bench parameters SHALL be DEBOUNCE_CYC = 8, SEQ_TIMEOUT = 100, STUCK_CYC = 200, SYNC_STAGES = 2.
REQ-026 Raw bit0 rises and is held -> sensor_clean[0] = 1 exactly 10 cycles later, with a single sensor_rise[0] pulse.
REQ-027 Raw bit1 pulsed high for 5 cycles -> sensor_clean[1] stays 0 and no rise pulse occurs.
REQ-028 Clean rises 1, 2, 3, spaced 20 cycles apart -> one seq_done pulse and no seq_error.
REQ-029 Each of the following -> exactly one seq_error:
- order 1, 3;
- rise1 followed by no further rise for 100 cycles;
- rise2 and rise3 in the same cycle.
REQ-030 Raw bit2 held high for 300 cycles -> stuck[2] rises 200 cycles after sensor_clean[2] rises, and clears with sensor_clean[2].
REQ-031 Reset asserted while in GOT2 -> all outputs are 0 immediately, with no seq_error pulse.

Source files
------------

// File: rtl/etc_pkg.sv
// Shared definitions for the vehicle-sensor conditioning path: channel count
// and the sequence FSM encoding.
package etc_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GOT1 = 2'd1,
    ST_GOT2 = 2'd2
  } seq_state_e;

  // True when more than one channel reports a rise in the same cycle.
  function automatic logic multi_hot(input logic [NUM_CH-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Sensor-side bundle of the conditioner: raw inputs in, cleaned levels,
// edge pulses, sequence verdicts and stuck flags out.
interface sensor_conditioner_if;
  import etc_pkg::*;

  logic [NUM_CH-1:0] sensor_raw;
  logic [NUM_CH-1:0] sensor_clean;
  logic [NUM_CH-1:0] sensor_rise;
  logic [NUM_CH-1:0] stuck;
  logic              seq_done;
  logic              seq_error;

  modport master (
    output sensor_raw,
    input  sensor_clean, sensor_rise, seq_done, seq_error, stuck
  );

  modport slave (
    input  sensor_raw,
    output sensor_clean, sensor_rise, seq_done, seq_error, stuck
  );

endinterface

// File: rtl/sensor_debounce.sv
// One sensor channel: multi-flop synchronizer, level debounce counter and
// registered rising-edge pulse aligned with the first high cleaned cycle.
module sensor_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
    cnt_d   = '0;
    clean_d = clean_q;
    // Counter only runs while the synchronized level disagrees with the output.
    if (sync_bit != clean_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        clean_d = ~clean_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = clean_d & ~clean_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions three vehicle sensors, checks the 1->2->3 pass order with a
// timeout, and flags channels whose cleaned level stays high too long.
//
// state   | meaning
// IDLE    | waiting for sensor1 rise
// GOT1    | sensor1 seen, waiting for sensor2 (timer running)
// GOT2    | sensor1,2 seen, waiting for sensor3 (timer running)
module sensor_conditioner
  import etc_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int SEQ_TIMEOUT  = 50000000,
  parameter int STUCK_CYC    = 100000000
) (
  input  logic                 clk,
  input  logic                 reset,
  sensor_conditioner_if.slave  bus
);

  localparam int TW = $clog2(SEQ_TIMEOUT + 1);
  localparam int SW = $clog2(STUCK_CYC + 1);

  logic [NUM_CH-1:0] clean;
  logic [NUM_CH-1:0] rise;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sensor_debounce #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.sensor_raw[g]),
      .clean (clean[g]),
      .rise  (rise[g])
    );
  end

  seq_state_e                  state_q, state_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic [NUM_CH-1:0][SW-1:0]   stk_q, stk_d;
  logic [NUM_CH-1:0]           stuck_w;

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    // Timeout wins over any rise landing in the same cycle.
    if (state_q != ST_IDLE && timer_q == TW'(SEQ_TIMEOUT)) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (multi_hot(rise)) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise[0]) begin
            state_d = ST_GOT1;
          end else if (rise[1] || rise[2]) begin
            err_d = 1'b1;
          end
        end
        ST_GOT1: begin
          if (rise[1]) begin
            state_d = ST_GOT2;
          end else if (rise[2]) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (!rise[0]) begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_GOT2: begin
          if (rise[2]) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (rise[0]) begin
            err_d   = 1'b1;
            state_d = ST_GOT1;
          end else if (rise[1]) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stk_d   = '0;
    stuck_w = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clean[i]) begin
        stk_d[i] = (stk_q[i] == SW'(STUCK_CYC)) ? stk_q[i] : stk_q[i] + SW'(1);
      end
      // Gated by the live level so the flag drops together with the channel.
      stuck_w[i] = clean[i] && (stk_q[i] == SW'(STUCK_CYC));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      stk_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      err_q   <= err_d;
      stk_q   <= stk_d;
    end
  end

  assign bus.sensor_clean = clean;
  assign bus.sensor_rise  = rise;
  assign bus.seq_done     = done_q;
  assign bus.seq_error    = err_q;
  assign bus.stuck        = stuck_w;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with short debounce/timeout/stuck
// settings; expectations are hand-derived cycle counts and pulse tallies.
module tb_sensor_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int TO   = 100;
  localparam int STK  = 200;

  logic clk = 1'b0;
  logic reset;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_err   = 0;
  int n_rise0 = 0;
  int n_rise1 = 0;
  int n_rise2 = 0;

  sensor_conditioner_if bus();

  sensor_conditioner #(
    .SYNC_STAGES  (SYNC),
    .DEBOUNCE_CYC (DEB),
    .SEQ_TIMEOUT  (TO),
    .STUCK_CYC    (STK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    n_done  += int'(bus.seq_done);
    n_err   += int'(bus.seq_error);
    n_rise0 += int'(bus.sensor_rise[0]);
    n_rise1 += int'(bus.sensor_rise[1]);
    n_rise2 += int'(bus.sensor_rise[2]);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_clean(input int ch, input logic lvl, input int bound, output int cyc);
    cyc = -1;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if (bus.sensor_clean[ch] == lvl) begin
        cyc = k;
        break;
      end
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {19'd0, bus.sensor_clean, bus.sensor_rise, bus.stuck, bus.seq_done, bus.seq_error};
  endfunction

  initial begin
    int c, e0, d0, r0, r1, r2;
    logic prev_stuck;

    reset = 1'b1;
    bus.sensor_raw = 3'b000;
    ticks(2);
    check("reset_outputs", all_outs(), 0);
    reset = 1'b0;

    // Rise on channel 0, latency, single pulse, then timeout with no further rise
    r0 = n_rise0; e0 = n_err; d0 = n_done;
    bus.sensor_raw = 3'b001;
    wait_clean(0, 1'b1, 30, c);
    check("deb_latency_ch0", c, SYNC + DEB);
    check("rise0_on", bus.sensor_rise[0], 1);
    tick();
    check("rise0_one_cycle", bus.sensor_rise[0], 0);
    ticks(TO);
    check("no_err_before_timeout", n_err - e0, 0);
    tick();
    check("timeout_err_pulse", bus.seq_error, 1);
    ticks(20);
    check("timeout_err_count", n_err - e0, 1);
    check("timeout_no_done", n_done - d0, 0);
    check("rise0_count", n_rise0 - r0, 1);
    bus.sensor_raw = 3'b000;
    ticks(15);
    check("ch0_fell", bus.sensor_clean[0], 0);
    check("ch0_no_fall_pulse", n_rise0 - r0, 1);

    // Glitches of 5 and 7 cycles are rejected; 8 cycles is accepted
    r1 = n_rise1; e0 = n_err;
    bus.sensor_raw = 3'b010; ticks(5);
    bus.sensor_raw = 3'b000; ticks(15);
    check("glitch5_clean", bus.sensor_clean[1], 0);
    check("glitch5_no_rise", n_rise1 - r1, 0);
    bus.sensor_raw = 3'b010; ticks(DEB - 1);
    bus.sensor_raw = 3'b000; ticks(15);
    check("glitch7_no_rise", n_rise1 - r1, 0);
    bus.sensor_raw = 3'b010; ticks(DEB);
    bus.sensor_raw = 3'b000; ticks(30);
    check("pulse8_rise", n_rise1 - r1, 1);
    check("idle_rise2_err", n_err - e0, 1);
    check("pulse8_fell", bus.sensor_clean[1], 0);

    // Valid 1,2,3 order
    e0 = n_err; d0 = n_done;
    bus.sensor_raw = 3'b001; ticks(20);
    bus.sensor_raw = 3'b011; ticks(20);
    bus.sensor_raw = 3'b111;
    wait_clean(2, 1'b1, 30, c);
    check("deb_latency_ch2", c, SYNC + DEB);
    tick();
    check("done_pulse", bus.seq_done, 1);
    tick();
    check("done_one_cycle", bus.seq_done, 0);
    ticks(20);
    check("seq123_done", n_done - d0, 1);
    check("seq123_no_err", n_err - e0, 0);
    bus.sensor_raw = 3'b000; ticks(20);

    // Order 1,3
    e0 = n_err; d0 = n_done;
    bus.sensor_raw = 3'b001; ticks(20);
    bus.sensor_raw = 3'b101; ticks(40);
    check("seq13_err", n_err - e0, 1);
    check("seq13_no_done", n_done - d0, 0);
    bus.sensor_raw = 3'b000; ticks(20);

    // Simultaneous 2,3 after a 1 (priority over GOT1->GOT2)
    e0 = n_err; d0 = n_done;
    bus.sensor_raw = 3'b001; ticks(20);
    bus.sensor_raw = 3'b111; ticks(40);
    check("multi_got1_err", n_err - e0, 1);
    check("multi_got1_no_done", n_done - d0, 0);
    bus.sensor_raw = 3'b000; ticks(20);

    // Simultaneous 2,3 from idle
    e0 = n_err;
    bus.sensor_raw = 3'b110; ticks(30);
    check("multi_idle_err", n_err - e0, 1);
    bus.sensor_raw = 3'b000; ticks(20);

    // Stuck flag on channel 2
    e0 = n_err; r2 = n_rise2;
    bus.sensor_raw = 3'b100;
    wait_clean(2, 1'b1, 30, c);
    c = -1;
    for (int k = 1; k <= 250; k++) begin
      tick();
      if (bus.stuck[2]) begin
        c = k;
        break;
      end
    end
    check("stuck_latency", c, STK);
    check("stuck_other_ch", {29'd0, bus.stuck}, 3'b100);
    ticks(80);
    check("stuck_held", bus.stuck[2], 1);
    bus.sensor_raw = 3'b000;
    c = -1;
    prev_stuck = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      prev_stuck = bus.stuck[2];
      tick();
      if (!bus.sensor_clean[2]) begin
        c = k;
        break;
      end
    end
    check("stuck_fall_latency", c, SYNC + DEB);
    check("stuck_before_fall", prev_stuck, 1);
    check("stuck_clears_with_clean", bus.stuck[2], 0);
    check("stuck_idle_err", n_err - e0, 1);
    check("stuck_rise_count", n_rise2 - r2, 1);
    ticks(10);

    // Reset while in GOT2, then release with raw bit0 already high
    bus.sensor_raw = 3'b001; ticks(20);
    bus.sensor_raw = 3'b011;
    wait_clean(1, 1'b1, 30, c);
    ticks(2);
    check("pre_reset_clean", {29'd0, bus.sensor_clean}, 3'b011);
    e0 = n_err; d0 = n_done;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", all_outs(), 0);
    ticks(3);
    check("reset_no_err", n_err - e0, 0);
    check("reset_no_done", n_done - d0, 0);
    bus.sensor_raw = 3'b001;
    r0 = n_rise0;
    reset = 1'b0;
    wait_clean(0, 1'b1, 30, c);
    check("post_reset_latency", c, SYNC + DEB);
    check("post_reset_rise", bus.sensor_rise[0], 1);
    ticks(5);
    check("post_reset_rise_count", n_rise0 - r0, 1);
    bus.sensor_raw = 3'b000;
    ticks(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
